mips150_lsu: RTL and testbench

Parametrised load/store unit for the MIPS150 pipeline, replacing the single-cycle, fixed-32-bit memory stage. It accepts one memory operation at a time from the X stage and decodes the target region (DMEM, IMEM, or IO). It drives a ready/valid memory port that tolerates wait states and returns sign- or zero-extended load data to writeback. It reports misaligned accesses and raises a busy signal so the hazard unit can stall the front end.

---
 rtl/mips150_lsu_if.sv | 51 +++++
 rtl/mips150_lsu.sv | 202 ++++++++++++++++++++
 tb/tb_mips150_lsu.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips150_lsu_if.sv
// mips150_lsu_if: request, memory-port and writeback signals of the MIPS150
// load/store unit, bundled so the pipeline, memory and LSU share one definition.
// The slave modport is the LSU itself. The master modport is the surrounding
// pipeline and memory system that feeds requests and answers memory traffic.
`timescale 1ns/1ps
interface mips150_lsu_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   localparam int NB = DATA_W / 8;

   logic              req_valid;
   logic              req_ready;
   logic              req_store;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [4:0]        req_rd;

   logic              mem_valid;
   logic              mem_ready;
   logic [1:0]        mem_sel;
   logic [ADDR_W-1:0] mem_addr;
   logic [NB-1:0]     mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_rvalid;
   logic [DATA_W-1:0] mem_rdata;

   logic              wb_valid;
   logic [4:0]        wb_rd;
   logic [DATA_W-1:0] wb_data;

   logic              busy;
   logic              misalign;
   logic [ADDR_W-1:0] bad_addr;

   modport master (
      output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, req_rd,
      output mem_ready, mem_rvalid, mem_rdata,
      input  req_ready, mem_valid, mem_sel, mem_addr, mem_we, mem_wdata,
      input  wb_valid, wb_rd, wb_data, busy, misalign, bad_addr
   );

   modport slave (
      input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, req_rd,
      input  mem_ready, mem_rvalid, mem_rdata,
      output req_ready, mem_valid, mem_sel, mem_addr, mem_we, mem_wdata,
      output wb_valid, wb_rd, wb_data, busy, misalign, bad_addr
   );
endinterface

// File: rtl/mips150_lsu.sv
// mips150_lsu: multi-cycle load/store unit for the MIPS150 memory stage.
// It takes one request at a time, decodes the region (DMEM/IMEM/IO), and drives
// a ready/valid memory port that can be stalled indefinitely. Loads come back
// sign- or zero-extended on a one-cycle writeback pulse. The byte order is
// big-endian: byte offset k sits in the top lanes.
// Optional feature macro: LSU_MISALIGN_TRAP_EN. When it is defined, misaligned
// requests are dropped and reported. When it is undefined, the low address bits
// are forced to zero and the access proceeds, as the legacy MIPS150 did.
`timescale 1ns/1ps
module mips150_lsu #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input logic          clk,
   input logic          rst,
   mips150_lsu_if.slave bus
);
   localparam int NB   = DATA_W / 8;
   localparam int OFFW = $clog2(NB);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t            state, stateNext;
   logic [1:0]        memSel, memSelNext;
   logic [ADDR_W-1:0] memAddr, memAddrNext;
   logic [NB-1:0]     memWe, memWeNext;
   logic [DATA_W-1:0] memWdata, memWdataNext;
   logic              isStore, isStoreNext;
   logic [OFFW-1:0]   ldOff, ldOffNext;
   logic [3:0]        ldBytes, ldBytesNext;
   logic              ldUnsigned, ldUnsignedNext;
   logic [4:0]        ldRd, ldRdNext;
   logic              wbValid, wbValidNext;
   logic [4:0]        wbRd, wbRdNext;
   logic [DATA_W-1:0] wbData, wbDataNext;
   logic              misalignQ, misalignNext;
   logic [ADDR_W-1:0] badAddr, badAddrNext;

   logic [1:0]        effSize;
   logic [3:0]        reqBytes;
   logic [3:0]        lowMask;
   logic [ADDR_W-1:0] alignedAddr;
   logic [OFFW-1:0]   reqOff;
   logic [1:0]        reqSel;
   logic [NB-1:0]     storeWe;
   logic [DATA_W-1:0] storeData;
   logic [DATA_W-1:0] loadData;
   logic              signBit;
   logic              trapHit;

   // A dword on a 32-bit datapath behaves as a word. The access is then aligned
   // to its own size, and the region is picked from the top address bits.
   always_comb begin
      effSize = bus.req_size;
      if (DATA_W == 32 && bus.req_size == 2'b11) effSize = 2'b10;
      reqBytes    = 4'd1 << effSize;
      lowMask     = reqBytes - 4'd1;
      alignedAddr = {bus.req_addr[ADDR_W-1:4], bus.req_addr[3:0] & ~lowMask};
      reqOff      = alignedAddr[OFFW-1:0];
      if (bus.req_addr[ADDR_W-1])                          reqSel = 2'b10;
      else if (bus.req_store && bus.req_addr[ADDR_W-3])    reqSel = 2'b01;
      else                                                 reqSel = 2'b00;
   end

`ifdef LSU_MISALIGN_TRAP_EN
   assign trapHit = |(bus.req_addr[3:0] & lowMask);
`else
   assign trapHit = 1'b0;
`endif

   // Place the right-justified store bytes into the lanes that start at the
   // byte offset. Lane k is the most significant byte still free.
   always_comb begin
      storeWe   = '0;
      storeData = '0;
      for (int i = 0; i < NB; i++) begin
         if (i >= int'(reqOff) && i < int'(reqOff) + int'(reqBytes)) begin
            storeWe[NB-1-i] = 1'b1;
            storeData[DATA_W-1-8*i -: 8] =
               bus.req_wdata[8*(int'(reqOff) + int'(reqBytes) - 1 - i) +: 8];
         end
      end
   end

   // Pull the latched lanes out of the returned word, right-justify them, and
   // fill the upper bytes with the sign bit (or with zero for unsigned loads).
   always_comb begin
      loadData = '0;
      signBit  = bus.mem_rdata[DATA_W-1-8*int'(ldOff)] & ~ldUnsigned;
      for (int j = 0; j < NB; j++) begin
         if (j < int'(ldBytes))
            loadData[8*j +: 8] =
               bus.mem_rdata[DATA_W-1-8*(int'(ldOff) + int'(ldBytes) - 1 - j) -: 8];
         else
            loadData[8*j +: 8] = {8{signBit}};
      end
   end

   // Next-state and next-register logic. Everything holds by default. The
   // writeback and misalign strobes default low, so each is a single-cycle pulse.
   always_comb begin
      stateNext      = state;
      memSelNext     = memSel;
      memAddrNext    = memAddr;
      memWeNext      = memWe;
      memWdataNext   = memWdata;
      isStoreNext    = isStore;
      ldOffNext      = ldOff;
      ldBytesNext    = ldBytes;
      ldUnsignedNext = ldUnsigned;
      ldRdNext       = ldRd;
      wbValidNext    = 1'b0;
      wbRdNext       = wbRd;
      wbDataNext     = wbData;
      misalignNext   = 1'b0;
      badAddrNext    = badAddr;
      case (state)
         IDLE: begin
            if (bus.req_valid) begin
               if (trapHit) begin
                  misalignNext = 1'b1;
                  badAddrNext  = bus.req_addr;
               end else begin
                  stateNext      = ISSUE;
                  memSelNext     = reqSel;
                  memAddrNext    = {alignedAddr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
                  memWeNext      = bus.req_store ? storeWe : '0;
                  memWdataNext   = bus.req_store ? storeData : '0;
                  isStoreNext    = bus.req_store;
                  ldOffNext      = reqOff;
                  ldBytesNext    = reqBytes;
                  ldUnsignedNext = bus.req_unsigned;
                  ldRdNext       = bus.req_rd;
               end
            end
         end
         ISSUE: begin
            if (bus.mem_ready) stateNext = isStore ? IDLE : WAIT;
         end
         WAIT: begin
            if (bus.mem_rvalid) begin
               wbValidNext = 1'b1;
               wbRdNext    = ldRd;
               wbDataNext  = loadData;
               stateNext   = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // State and output registers. A synchronous reset aborts any operation in
   // flight, so a late read response finds the unit idle and is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         memSel     <= '0;
         memAddr    <= '0;
         memWe      <= '0;
         memWdata   <= '0;
         isStore    <= 1'b0;
         ldOff      <= '0;
         ldBytes    <= '0;
         ldUnsigned <= 1'b0;
         ldRd       <= '0;
         wbValid    <= 1'b0;
         wbRd       <= '0;
         wbData     <= '0;
         misalignQ  <= 1'b0;
         badAddr    <= '0;
      end else begin
         state      <= stateNext;
         memSel     <= memSelNext;
         memAddr    <= memAddrNext;
         memWe      <= memWeNext;
         memWdata   <= memWdataNext;
         isStore    <= isStoreNext;
         ldOff      <= ldOffNext;
         ldBytes    <= ldBytesNext;
         ldUnsigned <= ldUnsignedNext;
         ldRd       <= ldRdNext;
         wbValid    <= wbValidNext;
         wbRd       <= wbRdNext;
         wbData     <= wbDataNext;
         misalignQ  <= misalignNext;
         badAddr    <= badAddrNext;
      end
   end

   assign bus.req_ready = (state == IDLE);
   assign bus.busy      = (state != IDLE);
   assign bus.mem_valid = (state == ISSUE);
   assign bus.mem_sel   = memSel;
   assign bus.mem_addr  = memAddr;
   assign bus.mem_we    = memWe;
   assign bus.mem_wdata = memWdata;
   assign bus.wb_valid  = wbValid;
   assign bus.wb_rd     = wbRd;
   assign bus.wb_data   = wbData;
   assign bus.misalign  = misalignQ;
   assign bus.bad_addr  = badAddr;
endmodule

// File: tb/tb_mips150_lsu.sv
// tb_mips150_lsu: directed bench for mips150_lsu. The 32-bit instance is
// checked every cycle against queued expectations built by a byte-arithmetic
// model. A 64-bit instance covers the dword lanes. Literal values pin the model.
// Also honours LSU_MISALIGN_TRAP_EN when the build defines it.
`timescale 1ns/1ps
module tb_mips150_lsu;
   logic clk = 1'b0;
   logic rst;
   int   compared   = 0;
   int   mismatched = 0;

   always #5 clk = ~clk;

   mips150_lsu_if #(.DATA_W(32), .ADDR_W(32)) bus ();
   mips150_lsu_if #(.DATA_W(64), .ADDR_W(32)) bus64 ();

   mips150_lsu #(.DATA_W(32), .ADDR_W(32)) dut   (.clk(clk), .rst(rst), .bus(bus));
   mips150_lsu #(.DATA_W(64), .ADDR_W(32)) dut64 (.clk(clk), .rst(rst), .bus(bus64));

   typedef struct {
      logic [1:0]  sel;
      logic [63:0] addr;
      logic [63:0] we;
      logic [63:0] wdata;
      bit          store;
   } memExp_t;

   typedef struct {
      logic [4:0]  rd;
      logic [63:0] data;
   } wbExp_t;

   memExp_t     memQ[$];
   wbExp_t      wbQ[$];
   logic [31:0] misQ[$];
   logic [31:0] expBadAddr = 32'h0;

   // Single comparison point: counts and reports any difference.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] laneMask(input int bytes);
      if (bytes >= 8) return 64'hFFFF_FFFF_FFFF_FFFF;
      return (64'd1 << (8 * bytes)) - 64'd1;
   endfunction

   function automatic int sizeBytes(input logic [1:0] size, input int nb);
      int s;
      s = int'(size);
      if (s == 3 && nb == 4) s = 2;
      return 1 << s;
   endfunction

   // Memory-side expectation: aligned address, lane enables and shifted data.
   function automatic memExp_t modelMem(input bit store, input logic [1:0] size,
                                        input logic [31:0] addr, input logic [63:0] wdata,
                                        input int nb);
      memExp_t e;
      int bytes, off, shift;
      logic [31:0] a;
      bytes   = sizeBytes(size, nb);
      a       = addr - (addr % 32'(bytes));
      off     = int'(a % 32'(nb));
      shift   = nb - off - bytes;
      e.sel   = addr[31] ? 2'b10 : ((store && addr[29]) ? 2'b01 : 2'b00);
      e.addr  = 64'(a - (a % 32'(nb)));
      e.we    = store ? (((64'd1 << bytes) - 64'd1) << shift) : 64'h0;
      e.wdata = store ? ((wdata & laneMask(bytes)) << (8 * shift)) : 64'h0;
      e.store = store;
      return e;
   endfunction

   // Load result: shift the addressed bytes down, then sign- or zero-extend.
   function automatic logic [63:0] modelLoad(input logic [1:0] size, input bit uns,
                                             input logic [31:0] addr, input logic [63:0] rdata,
                                             input int nb);
      int bytes, off, shift;
      logic [31:0] a;
      logic [63:0] v;
      bytes = sizeBytes(size, nb);
      a     = addr - (addr % 32'(bytes));
      off   = int'(a % 32'(nb));
      shift = nb - off - bytes;
      v     = (rdata >> (8 * shift)) & laneMask(bytes);
      if (!uns && bytes < 8 && v[8*bytes-1]) v = v | ~laneMask(bytes);
      if (nb == 4) v = v & 64'h0000_0000_FFFF_FFFF;
      return v;
   endfunction

   // Per-cycle compare of the 32-bit instance against the queued expectations.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.mem_valid) begin
            if (memQ.size() == 0) checkOutput("memUnexpected", 64'(bus.mem_valid), 64'h0);
            else begin
               checkOutput("memSel",  64'(bus.mem_sel),  64'(memQ[0].sel));
               checkOutput("memAddr", 64'(bus.mem_addr), memQ[0].addr);
               checkOutput("memWe",   64'(bus.mem_we),   memQ[0].we);
               if (memQ[0].store) checkOutput("memWdata", 64'(bus.mem_wdata), memQ[0].wdata);
               if (bus.mem_ready) void'(memQ.pop_front());
            end
         end
         if (bus.wb_valid) begin
            if (wbQ.size() == 0) checkOutput("wbUnexpected", 64'(bus.wb_valid), 64'h0);
            else begin
               checkOutput("wbRd",   64'(bus.wb_rd),   64'(wbQ[0].rd));
               checkOutput("wbData", 64'(bus.wb_data), wbQ[0].data);
               void'(wbQ.pop_front());
            end
         end
         if (bus.misalign) begin
            if (misQ.size() == 0) checkOutput("misalignUnexpected", 64'(bus.misalign), 64'h0);
            else begin
               expBadAddr = misQ.pop_front();
            end
         end
         checkOutput("badAddr", 64'(bus.bad_addr), 64'(expBadAddr));
         checkOutput("busyVsReady", 64'(bus.busy), 64'(!bus.req_ready));
      end
   end

   // Drive one operation into the 32-bit instance. Every call starts just after
   // a rising edge. The memory holds mem_ready low for readyDelay cycles and
   // sends stray rvalids, which the LSU must ignore while it is issuing.
   task automatic applyStimulus(input bit store, input logic [1:0] size, input bit uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [4:0] rd, input int readyDelay,
                                input logic [31:0] rdata);
      int guard;
      int bytes;
      bit trap;
      wbExp_t w;
      guard = 0;
      while (!bus.req_ready && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!bus.req_ready) begin
         checkOutput("reqReadyTimeout", 64'(bus.req_ready), 64'h1);
         return;
      end
      bytes = sizeBytes(size, 4);
      trap  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      trap = (addr % 32'(bytes)) != 32'h0;
`endif
      if (trap) misQ.push_back(addr);
      else begin
         memQ.push_back(modelMem(store, size, addr, {32'h0, wdata}, 4));
         if (!store) begin
            w.rd   = rd;
            w.data = modelLoad(size, uns, addr, {32'h0, rdata}, 4);
            wbQ.push_back(w);
         end
      end
      bus.req_valid    = 1'b1;
      bus.req_store    = store;
      bus.req_size     = size;
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wdata;
      bus.req_rd       = rd;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      if (trap) return;
      for (int i = 0; i < readyDelay; i++) begin
         checkOutput("busyWhileStalled", 64'(bus.busy), 64'h1);
         bus.mem_rvalid = 1'b1;
         bus.mem_rdata  = 32'hDEAD_0000 + 32'(i);
         @(posedge clk); #1;
      end
      bus.mem_rvalid = 1'b0;
      bus.mem_ready  = 1'b1;
      @(posedge clk); #1;
      bus.mem_ready = 1'b0;
      if (!store) begin
         bus.mem_rdata  = rdata;
         bus.mem_rvalid = 1'b1;
         @(posedge clk); #1;
         bus.mem_rvalid = 1'b0;
      end
   endtask

   // Let pending pulses go by, then confirm every expectation was consumed.
   task automatic drain();
      repeat (3) @(posedge clk);
      #1;
      checkOutput("memQueueLeft", 64'(memQ.size()), 64'h0);
      checkOutput("wbQueueLeft",  64'(wbQ.size()),  64'h0);
      checkOutput("misQueueLeft", 64'(misQ.size()), 64'h0);
      checkOutput("busyIdle",     64'(bus.busy),    64'h0);
      memQ.delete();
      wbQ.delete();
      misQ.delete();
   endtask

   // One operation on the 64-bit instance, checked inline against the model.
   task automatic op64(input bit store, input logic [1:0] size, input bit uns,
                       input logic [31:0] addr, input logic [63:0] wdata,
                       input logic [4:0] rd, input logic [63:0] rdata);
      memExp_t e;
      e = modelMem(store, size, addr, wdata, 8);
      bus64.req_valid    = 1'b1;
      bus64.req_store    = store;
      bus64.req_size     = size;
      bus64.req_unsigned = uns;
      bus64.req_addr     = addr;
      bus64.req_wdata    = wdata;
      bus64.req_rd       = rd;
      @(posedge clk); #1;
      bus64.req_valid = 1'b0;
      checkOutput("m64Valid", 64'(bus64.mem_valid), 64'h1);
      checkOutput("m64Addr",  64'(bus64.mem_addr),  e.addr);
      checkOutput("m64We",    64'(bus64.mem_we),    e.we);
      checkOutput("m64Sel",   64'(bus64.mem_sel),   64'(e.sel));
      if (store) checkOutput("m64Wdata", bus64.mem_wdata, e.wdata);
      bus64.mem_ready = 1'b1;
      @(posedge clk); #1;
      bus64.mem_ready = 1'b0;
      if (!store) begin
         bus64.mem_rdata  = rdata;
         bus64.mem_rvalid = 1'b1;
         @(posedge clk); #1;
         bus64.mem_rvalid = 1'b0;
         checkOutput("w64Valid", 64'(bus64.wb_valid), 64'h1);
         checkOutput("w64Rd",    64'(bus64.wb_rd),    64'(rd));
         checkOutput("w64Data",  bus64.wb_data,       modelLoad(size, uns, addr, rdata, 8));
         @(posedge clk); #1;
         checkOutput("w64Pulse", 64'(bus64.wb_valid), 64'h0);
      end else begin
         checkOutput("s64Ready", 64'(bus64.req_ready), 64'h1);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1;
      bus.req_valid = 1'b0;   bus.req_store = 1'b0;  bus.req_size = 2'b00;
      bus.req_unsigned = 1'b0; bus.req_addr = '0;    bus.req_wdata = '0;
      bus.req_rd = '0;        bus.mem_ready = 1'b0;  bus.mem_rvalid = 1'b0;
      bus.mem_rdata = '0;
      bus64.req_valid = 1'b0; bus64.req_store = 1'b0; bus64.req_size = 2'b00;
      bus64.req_unsigned = 1'b0; bus64.req_addr = '0; bus64.req_wdata = '0;
      bus64.req_rd = '0;      bus64.mem_ready = 1'b0; bus64.mem_rvalid = 1'b0;
      bus64.mem_rdata = '0;
      repeat (3) @(posedge clk);
      #1;

      checkOutput("rstReqReady", 64'(bus.req_ready), 64'h1);
      checkOutput("rstMemValid", 64'(bus.mem_valid), 64'h0);
      checkOutput("rstMemWe",    64'(bus.mem_we),    64'h0);
      checkOutput("rstMemSel",   64'(bus.mem_sel),   64'h0);
      checkOutput("rstMemAddr",  64'(bus.mem_addr),  64'h0);
      checkOutput("rstMemWdata", 64'(bus.mem_wdata), 64'h0);
      checkOutput("rstWbValid",  64'(bus.wb_valid),  64'h0);
      checkOutput("rstWbRd",     64'(bus.wb_rd),     64'h0);
      checkOutput("rstWbData",   64'(bus.wb_data),   64'h0);
      checkOutput("rstBusy",     64'(bus.busy),      64'h0);
      checkOutput("rstMisalign", 64'(bus.misalign),  64'h0);
      checkOutput("rstBadAddr",  64'(bus.bad_addr),  64'h0);
      checkOutput("rst64Ready",  64'(bus64.req_ready), 64'h1);
      rst = 1'b0;
      @(posedge clk); #1;

      $display("[TB] SB to DMEM at offset 3");
      applyStimulus(1'b1, 2'b00, 1'b0, 32'h1000_0003, 32'h0000_00AB, 5'd0, 0, 32'h0);
      drain();
      checkOutput("sbLitWe",    64'(bus.mem_we),    64'h1);
      checkOutput("sbLitWdata", 64'(bus.mem_wdata), 64'h0000_00AB);
      checkOutput("sbLitAddr",  64'(bus.mem_addr),  64'h1000_0000);
      checkOutput("sbLitSel",   64'(bus.mem_sel),   64'h0);

      $display("[TB] LB then LBU at offset 1");
      applyStimulus(1'b0, 2'b00, 1'b0, 32'h1000_0001, 32'h0, 5'd5, 0, 32'h1180_2233);
      drain();
      checkOutput("lbLitData", 64'(bus.wb_data), 64'hFFFF_FF80);
      checkOutput("lbLitRd",   64'(bus.wb_rd),   64'h5);
      applyStimulus(1'b0, 2'b00, 1'b1, 32'h1000_0001, 32'h0, 5'd5, 0, 32'h1180_2233);
      drain();
      checkOutput("lbuLitData", 64'(bus.wb_data), 64'h0000_0080);

      $display("[TB] SW to IMEM with a stalled memory, LW from IO");
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h2000_0004, 32'hCAFE_F00D, 5'd0, 4, 32'h0);
      drain();
      checkOutput("swLitSel", 64'(bus.mem_sel), 64'h1);
      checkOutput("swLitWe",  64'(bus.mem_we),  64'hF);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h8000_0000, 32'h0, 5'd7, 2, 32'h8765_4321);
      drain();
      checkOutput("lwLitSel",  64'(bus.mem_sel), 64'h2);
      checkOutput("lwLitData", 64'(bus.wb_data), 64'h8765_4321);

      $display("[TB] LH at a misaligned address");
      applyStimulus(1'b0, 2'b01, 1'b0, 32'h0000_0003, 32'h0, 5'd9, 0, 32'h1180_A233);
      drain();
`ifdef LSU_MISALIGN_TRAP_EN
      checkOutput("trapLitBad", 64'(bus.bad_addr), 64'h3);
`else
      checkOutput("lhLitData", 64'(bus.wb_data), 64'hFFFF_A233);
      checkOutput("lhLitWe",   64'(bus.mem_we),  64'h0);
      checkOutput("lhLitAddr", 64'(bus.mem_addr), 64'h0);
`endif

      $display("[TB] halfword lanes and dword on the 32-bit datapath");
      applyStimulus(1'b1, 2'b01, 1'b0, 32'h0000_0100, 32'hFFFF_1234, 5'd0, 0, 32'h0);
      drain();
      checkOutput("shLitWe",    64'(bus.mem_we),    64'hC);
      checkOutput("shLitWdata", 64'(bus.mem_wdata), 64'h1234_0000);
      applyStimulus(1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h0000_5678, 5'd0, 1, 32'h0);
      applyStimulus(1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0, 5'd4, 0, 32'h0000_F00D);
      drain();
      checkOutput("lhuLitData", 64'(bus.wb_data), 64'h0000_F00D);
      applyStimulus(1'b1, 2'b11, 1'b0, 32'h0000_0008, 32'h0BAD_BEEF, 5'd0, 0, 32'h0);
      drain();
      checkOutput("sdAsWordWe", 64'(bus.mem_we), 64'hF);

      $display("[TB] back-to-back loads, next accepted during the writeback pulse");
      applyStimulus(1'b0, 2'b00, 1'b0, 32'h0000_0003, 32'h0, 5'd1, 0, 32'h0000_00FF);
      applyStimulus(1'b0, 2'b00, 1'b1, 32'h0000_0002, 32'h0, 5'd2, 0, 32'h0000_7F00);
      drain();
      checkOutput("b2bLitData", 64'(bus.wb_data), 64'h0000_007F);

      $display("[TB] reset while waiting for read data");
      memQ.push_back(modelMem(1'b0, 2'b10, 32'h0000_0040, 64'h0, 4));
      bus.req_valid = 1'b1;  bus.req_store = 1'b0;  bus.req_size = 2'b10;
      bus.req_unsigned = 1'b0; bus.req_addr = 32'h0000_0040; bus.req_rd = 5'd3;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      bus.mem_ready = 1'b1;
      @(posedge clk); #1;
      bus.mem_ready = 1'b0;
      checkOutput("busyInWait", 64'(bus.busy), 64'h1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      expBadAddr = 32'h0;
      checkOutput("readyAfterRst", 64'(bus.req_ready), 64'h1);
      checkOutput("busyAfterRst",  64'(bus.busy),      64'h0);
      bus.mem_rdata  = 32'h1234_5678;
      bus.mem_rvalid = 1'b1;
      @(posedge clk); #1;
      bus.mem_rvalid = 1'b0;
      checkOutput("noWbAfterRst",  64'(bus.wb_valid),  64'h0);
      checkOutput("idleAfterLate", 64'(bus.req_ready), 64'h1);
      drain();

      $display("[TB] 64-bit datapath");
      op64(1'b1, 2'b11, 1'b0, 32'h0000_0008, 64'h0123_4567_89AB_CDEF, 5'd0, 64'h0);
      checkOutput("sdLitWe",    64'(bus64.mem_we),   64'hFF);
      checkOutput("sdLitWdata", bus64.mem_wdata,     64'h0123_4567_89AB_CDEF);
      checkOutput("sdLitAddr",  64'(bus64.mem_addr), 64'h8);
      op64(1'b0, 2'b01, 1'b0, 32'h0000_0006, 64'h0, 5'd12, 64'h1111_2222_3333_8001);
      checkOutput("lh64LitData", bus64.wb_data, 64'hFFFF_FFFF_FFFF_8001);
      op64(1'b0, 2'b10, 1'b0, 32'h0000_0004, 64'h0, 5'd13, 64'h0000_0000_8000_0000);
      checkOutput("lw64LitData", bus64.wb_data, 64'hFFFF_FFFF_8000_0000);
      op64(1'b1, 2'b00, 1'b0, 32'h0000_0005, 64'h0000_0000_0000_005A, 5'd0, 64'h0);
      checkOutput("sb64LitWe",    64'(bus64.mem_we), 64'h04);
      checkOutput("sb64LitWdata", bus64.mem_wdata,   64'h0000_0000_005A_0000);

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
